// File: rtl/alu_issue.sv
// ============================================================================
// alu_issue : instruction issue FIFO feeding the registered alu operand bus
// Revision  : 1.0
// ============================================================================
`default_nettype none

module alu_issue #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           in_vld,
  input  logic [10:0]                    in_instr,
  output logic                           in_rdy,
  input  logic                           stall,
  input  logic                           flush,
  output logic [2:0]                     OPCODE,
  output logic [3:0]                     OP1,
  output logic [3:0]                     OP2,
  output logic                           issue_vld,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic [CW-1:0]                  issue_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH+1);
  localparam logic [NW-1:0] C_DEPTH = NW'(DEPTH);

  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [NW-1:0] r_count;
  logic [2:0]    r_opcode;
  logic [3:0]    r_op1;
  logic [3:0]    r_op2;
  logic          r_issue_vld;
  logic [CW-1:0] r_issue_cnt;

  logic          w_push;
  logic          w_pop;
  logic          w_nonempty;
  logic [10:0]   w_head;

  // Ready looks only at registered occupancy, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_rdy     = (r_count < C_DEPTH);
  assign w_nonempty = (r_count != '0);
  assign w_push     = in_vld & in_rdy & ~flush;
  assign w_pop      = ~stall & w_nonempty & ~flush;
  assign w_head     = r_mem[r_rptr];

  // Storage carries no reset; occupancy tracking makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_instr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + NW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - NW'(1);
      end
    end
  end

  // Issue stage: loads the head entry, or the all-zero idle encoding when empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_opcode    <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_issue_vld <= 1'b0;
      r_issue_cnt <= '0;
    end else if (flush) begin
      r_opcode    <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_issue_vld <= 1'b0;
    end else if (!stall) begin
      if (w_nonempty) begin
        r_opcode    <= w_head[10:8];
        r_op1       <= w_head[7:4];
        r_op2       <= w_head[3:0];
        r_issue_vld <= 1'b1;
        r_issue_cnt <= r_issue_cnt + CW'(1);
      end else begin
        r_opcode    <= '0;
        r_op1       <= '0;
        r_op2       <= '0;
        r_issue_vld <= 1'b0;
      end
    end
  end

  assign OPCODE    = r_opcode;
  assign OP1       = r_op1;
  assign OP2       = r_op2;
  assign issue_vld = r_issue_vld;
  assign count     = r_count;
  assign issue_cnt = r_issue_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// ============================================================================
// tb_alu_issue : directed scoreboard bench for alu_issue
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue;

  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_vld;
  logic [10:0] in_instr;
  logic        in_rdy;
  logic        stall;
  logic        flush;
  logic [2:0]  OPCODE;
  logic [3:0]  OP1;
  logic [3:0]  OP2;
  logic        issue_vld;
  logic [2:0]  count;
  logic [7:0]  issue_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  logic [10:0] sb[$];
  logic [7:0]  prev_cnt = '0;

  alu_issue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_instr(in_instr),
    .in_rdy(in_rdy), .stall(stall), .flush(flush), .OPCODE(OPCODE),
    .OP1(OP1), .OP2(OP2), .issue_vld(issue_vld), .count(count),
    .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One cycle: drive at negedge, confirm hand-predicted ready, return 1 time unit after the edge.
  task automatic drv(input logic v, input logic [10:0] w, input logic s,
                     input logic f, input logic er);
    @(negedge clk);
    in_vld = v; in_instr = w; stall = s; flush = f;
    #1;
    chk("in_rdy", {31'd0, in_rdy}, {31'd0, er});
    if (f) sb.delete();
    else if (v && er) sb.push_back(w);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_vld"}, {31'd0, issue_vld}, 32'd0);
    chk({tag, "_bus"}, {21'd0, OPCODE, OP1, OP2}, 32'd0);
  endtask

  // Monitor: every new issue (issue counter advanced with a live bus) must match the oldest pushed word.
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      prev_cnt = '0;
    end else begin
      if (issue_vld && issue_cnt != prev_cnt) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow: issued %0h with nothing expected", {OPCODE, OP1, OP2});
        end else begin
          chk("issue_word", {21'd0, OPCODE, OP1, OP2}, {21'd0, sb.pop_front()});
        end
      end
      prev_cnt = issue_cnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; in_vld = 1'b0; in_instr = '0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_issue_cnt", {24'd0, issue_cnt}, 32'd0);
    chk_idle_bus("rst");
    @(negedge clk);
    rstn = 1'b1;

    // Single word, empty FIFO: stored first, issued on the following edge.
    drv(1'b1, {3'b010, 4'h5, 4'h3}, 1'b0, 1'b0, 1'b1);
    chk("t1_count", {29'd0, count}, 32'd1);
    chk("t1_vld_early", {31'd0, issue_vld}, 32'd0);
    drv(1'b0, 11'h0, 1'b0, 1'b0, 1'b1);
    chk("t1_bus", {21'd0, OPCODE, OP1, OP2}, {21'd0, 3'b010, 4'h5, 4'h3});
    chk("t1_vld", {31'd0, issue_vld}, 32'd1);
    chk("t1_issue_cnt", {24'd0, issue_cnt}, 32'd1);
    drv(1'b0, 11'h0, 1'b0, 1'b0, 1'b1);
    chk_idle_bus("t1_after");

    // Fill under stall, reject a fifth word, then drain in order.
    for (int i = 0; i < 4; i++) drv(1'b1, 11'h100 + 11'(i), 1'b1, 1'b0, 1'b1);
    chk("t2_count_full", {29'd0, count}, 32'd4);
    drv(1'b1, 11'h7FF, 1'b1, 1'b0, 1'b0);
    chk("t2_count_hold", {29'd0, count}, 32'd4);
    chk("t2_vld_stalled", {31'd0, issue_vld}, 32'd0);
    drv(1'b0, 11'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drv(1'b0, 11'h0, 1'b0, 1'b0, 1'b1);
    chk("t2_vld", {31'd0, issue_vld}, 32'd1);
    chk("t2_issue_cnt", {24'd0, issue_cnt}, 32'd5);
    chk("t2_count_empty", {29'd0, count}, 32'd0);
    chk("t2_in_rdy", {31'd0, in_rdy}, 32'd1);

    // Full FIFO with continuous offers: order preserved across pointer wrap.
    for (int i = 0; i < 4; i++) drv(1'b1, 11'h200 + 11'(i), 1'b1, 1'b0, 1'b1);
    drv(1'b1, 11'h2FF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) drv(1'b1, 11'h300 + 11'(i), 1'b0, 1'b0, 1'b1);
    chk("t3_count_steady", {29'd0, count}, 32'd3);
    for (int i = 0; i < 4; i++) drv(1'b0, 11'h0, 1'b0, 1'b0, 1'b1);
    chk("t3_issue_cnt", {24'd0, issue_cnt}, 32'd20);
    chk("t3_sb_empty", sb.size(), 32'd0);
    chk_idle_bus("t3_idle");

    // Flush with a live bus, two queued words and a word on offer.
    drv(1'b1, 11'h411, 1'b0, 1'b0, 1'b1);
    drv(1'b1, 11'h422, 1'b0, 1'b0, 1'b1);
    drv(1'b1, 11'h433, 1'b1, 1'b0, 1'b1);
    chk("t4_count_pre", {29'd0, count}, 32'd2);
    chk("t4_vld_pre", {31'd0, issue_vld}, 32'd1);
    drv(1'b1, 11'h444, 1'b1, 1'b1, 1'b1);
    chk("t4_count", {29'd0, count}, 32'd0);
    chk_idle_bus("t4_flush");
    chk("t4_issue_cnt", {24'd0, issue_cnt}, 32'd21);
    drv(1'b0, 11'h0, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 11'h0, 1'b0, 1'b0, 1'b1);
    chk_idle_bus("t4_dropped");

    // Asynchronous reset between edges while a word is live and three are queued.
    drv(1'b1, 11'h511, 1'b0, 1'b0, 1'b1);
    drv(1'b1, 11'h522, 1'b0, 1'b0, 1'b1);
    drv(1'b1, 11'h533, 1'b1, 1'b0, 1'b1);
    drv(1'b1, 11'h544, 1'b1, 1'b0, 1'b1);
    chk("t5_count_pre", {29'd0, count}, 32'd3);
    chk("t5_vld_pre", {31'd0, issue_vld}, 32'd1);
    #2;
    rstn = 1'b0; in_vld = 1'b0; stall = 1'b0;
    sb.delete();
    #1;
    chk("t5_count", {29'd0, count}, 32'd0);
    chk("t5_issue_cnt", {24'd0, issue_cnt}, 32'd0);
    chk("t5_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk_idle_bus("t5_rst");
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("t5_rdy_release", {31'd0, in_rdy}, 32'd1);

    // 256 issues: counter wraps to zero on the last one.
    for (int i = 0; i < 256; i++) drv(1'b1, 11'(i), 1'b0, 1'b0, 1'b1);
    chk("t6_cnt_255", {24'd0, issue_cnt}, 32'd255);
    chk("t6_count", {29'd0, count}, 32'd1);
    drv(1'b0, 11'h0, 1'b0, 1'b0, 1'b1);
    chk("t6_cnt_wrap", {24'd0, issue_cnt}, 32'd0);
    chk("t6_vld", {31'd0, issue_vld}, 32'd1);
    drv(1'b0, 11'h0, 1'b0, 1'b0, 1'b1);
    chk_idle_bus("t6_end");
    chk("t6_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
